// File: rtl/pong_game_ctrl_pkg.sv
// Shared pong encodings: FSM states and winner codes used by the controller, animator and score display.
// Pure declarations; no clocked logic and no flow control.
package pong_pkg;

    localparam int SCORE_W_DEF = 5;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_POINT     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    typedef logic [1:0] winner_t;

    localparam winner_t WIN_NONE = 2'b00;
    localparam winner_t WIN_P1   = 2'b01;
    localparam winner_t WIN_P2   = 2'b10;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Event/status bundle between the game sequencer (master) and the animator/display side (slave).
// Events are single-cycle pulses or levels; no backpressure, the sequencer never stalls its inputs.
interface pong_game_ctrl_if
    import pong_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF
);
    logic               frame_tick;
    logic               start;
    logic               pause;
    logic               miss_left;
    logic               miss_right;
    logic               ball_load;
    logic               ball_run;
    logic               serve_dir;
    logic [SCORE_W-1:0] score_p1;
    logic [SCORE_W-1:0] score_p2;
    winner_t            winner;
    logic [2:0]         state;

    modport master (
        input  frame_tick, start, pause, miss_left, miss_right,
        output ball_load, ball_run, serve_dir, score_p1, score_p2, winner, state
    );

    modport slave (
        output frame_tick, start, pause, miss_left, miss_right,
        input  ball_load, ball_run, serve_dir, score_p1, score_p2, winner, state
    );
endinterface

// File: rtl/pong_game_ctrl_frame_timer.sv
// Frame counter with synchronous clear; o_done is combinational on the tick that hits terminal count.
// Zero latency on done; counting simply stalls while i_en is low.
module frame_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_tick,
    input  logic [CNT_W-1:0] i_tc,
    output logic             o_done
);
    logic [CNT_W-1:0] r_cnt;
    logic             w_step;

    assign w_step = i_en & i_tick;
    assign o_done = w_step & (r_cnt == i_tc);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (w_step) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: scores, serve direction, ball load/run enables, winner; all outputs registered.
// One-cycle output latency; no backpressure, misses outside unpaused PLAY are dropped.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 11,
    parameter int SCORE_W      = SCORE_W_DEF,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30
) (
    input  logic             clk,
    input  logic             reset_n,
    pong_game_ctrl_if.master bus
);
    localparam int TMR_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [SCORE_W-1:0] L_WIN      = SCORE_W'(WIN_SCORE);
    localparam logic [TMR_W-1:0]   L_SERVE_TC = TMR_W'(SERVE_FRAMES - 1);
    localparam logic [TMR_W-1:0]   L_POINT_TC = TMR_W'(POINT_FRAMES - 1);

    state_t             r_state;
    logic [SCORE_W-1:0] r_score_p1;
    logic [SCORE_W-1:0] r_score_p2;
    logic               r_serve_dir;
    winner_t            r_winner;
    logic               r_ball_load;
    logic               r_ball_run;
    logic               r_start_q;

    state_t             w_state_nxt;
    logic [SCORE_W-1:0] w_p1_nxt;
    logic [SCORE_W-1:0] w_p2_nxt;
    logic               w_dir_nxt;
    winner_t            w_winner_nxt;
    logic               w_load_nxt;
    logic               w_run_nxt;
    logic               w_start_rise;
    logic               w_tmr_clr;
    logic               w_tmr_en;
    logic               w_tmr_done;
    logic [TMR_W-1:0]   w_tmr_tc;

    assign w_start_rise = bus.start & ~r_start_q;

    // Timer restarts on every state change, so a tick coincident with a transition belongs to the old state.
    assign w_tmr_clr = (w_state_nxt != r_state) ||
                       !((r_state == ST_SERVE) || (r_state == ST_POINT));
    assign w_tmr_en  = ((r_state == ST_SERVE) & ~bus.pause) | (r_state == ST_POINT);
    assign w_tmr_tc  = (r_state == ST_POINT) ? L_POINT_TC : L_SERVE_TC;

    frame_timer #(
        .CNT_W (TMR_W)
    ) u_frame_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_tmr_clr),
        .i_en    (w_tmr_en),
        .i_tick  (bus.frame_tick),
        .i_tc    (w_tmr_tc),
        .o_done  (w_tmr_done)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_p1_nxt     = r_score_p1;
        w_p2_nxt     = r_score_p2;
        w_dir_nxt    = r_serve_dir;
        w_winner_nxt = r_winner;
        w_load_nxt   = 1'b0;

        case (r_state)
            ST_IDLE, ST_GAME_OVER: begin
                if (w_start_rise) begin
                    w_state_nxt  = ST_SERVE;
                    w_p1_nxt     = '0;
                    w_p2_nxt     = '0;
                    w_winner_nxt = WIN_NONE;
                    w_load_nxt   = 1'b1;
                end
            end
            ST_SERVE: begin
                if (w_tmr_done) begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (!bus.pause && (bus.miss_left || bus.miss_right)) begin
                    w_state_nxt = ST_POINT;
                    if (bus.miss_left && bus.miss_right) begin
                        w_dir_nxt = ~r_serve_dir;
                    end else if (bus.miss_right) begin
                        w_dir_nxt = 1'b0;
                        if (r_score_p1 < L_WIN) begin
                            w_p1_nxt = r_score_p1 + SCORE_W'(1);
                        end
                    end else begin
                        w_dir_nxt = 1'b1;
                        if (r_score_p2 < L_WIN) begin
                            w_p2_nxt = r_score_p2 + SCORE_W'(1);
                        end
                    end
                end
            end
            ST_POINT: begin
                if (w_tmr_done) begin
                    if (r_score_p1 == L_WIN) begin
                        w_state_nxt  = ST_GAME_OVER;
                        w_winner_nxt = WIN_P1;
                    end else if (r_score_p2 == L_WIN) begin
                        w_state_nxt  = ST_GAME_OVER;
                        w_winner_nxt = WIN_P2;
                    end else begin
                        w_state_nxt = ST_SERVE;
                        w_load_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_run_nxt = (w_state_nxt == ST_PLAY) & ~bus.pause;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_score_p1  <= '0;
            r_score_p2  <= '0;
            r_serve_dir <= 1'b0;
            r_winner    <= WIN_NONE;
            r_ball_load <= 1'b0;
            r_ball_run  <= 1'b0;
            r_start_q   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_score_p1  <= w_p1_nxt;
            r_score_p2  <= w_p2_nxt;
            r_serve_dir <= w_dir_nxt;
            r_winner    <= w_winner_nxt;
            r_ball_load <= w_load_nxt;
            r_ball_run  <= w_run_nxt;
            r_start_q   <= bus.start;
        end
    end

    assign bus.state     = r_state;
    assign bus.score_p1  = r_score_p1;
    assign bus.score_p2  = r_score_p2;
    assign bus.serve_dir = r_serve_dir;
    assign bus.winner    = r_winner;
    assign bus.ball_load = r_ball_load;
    assign bus.ball_run  = r_ball_run;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed vector table, hand-written game/reset sequences, random stimulus.
// A per-cycle reference model built from the game rules checks every output on every cycle.
module tb_pong_game_ctrl;
    localparam int WIN = 11;
    localparam int SW  = 5;
    localparam int SF  = 60;
    localparam int PF  = 30;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pong_game_ctrl_if #(.SCORE_W(SW)) bus ();

    pong_game_ctrl #(
        .WIN_SCORE    (WIN),
        .SCORE_W      (SW),
        .SERVE_FRAMES (SF),
        .POINT_FRAMES (PF)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_cyc    = 0;
    int load_seen = 0;

    // Reference model: mode codes 0 idle, 1 serve, 2 play, 3 point, 4 game over.
    int m_state, m_p1, m_p2, m_dir, m_win, m_left, m_load, m_run, m_sq;

    typedef struct {
        bit ft, st, pa, ml, mr;
        int n;
        int e_state, e_p1, e_p2, e_dir, e_win, e_run, e_loads;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_state = 0; m_p1 = 0; m_p2 = 0; m_dir = 0; m_win = 0;
        m_left = 0; m_load = 0; m_run = 0; m_sq = 0;
    endtask

    task automatic m_step(input bit ft, input bit st, input bit pa, input bit ml, input bit mr);
        bit rise;
        rise = st && (m_sq == 0);
        m_sq = st;
        m_load = 0;
        case (m_state)
            0, 4: if (rise) begin
                m_state = 1; m_p1 = 0; m_p2 = 0; m_win = 0; m_load = 1; m_left = SF;
            end
            1: if (ft && !pa) begin
                m_left--;
                if (m_left == 0) m_state = 2;
            end
            2: if (!pa && (ml || mr)) begin
                if (ml && mr) m_dir = 1 - m_dir;
                else if (mr) begin m_p1 = (m_p1 < WIN) ? m_p1 + 1 : WIN; m_dir = 0; end
                else begin m_p2 = (m_p2 < WIN) ? m_p2 + 1 : WIN; m_dir = 1; end
                m_state = 3;
                m_left = PF;
            end
            3: if (ft) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_p1 == WIN || m_p2 == WIN) begin
                        m_state = 4;
                        m_win = (m_p1 == WIN) ? 1 : 2;
                    end else begin
                        m_state = 1; m_left = SF; m_load = 1;
                    end
                end
            end
            default: ;
        endcase
        m_run = (m_state == 2 && !pa) ? 1 : 0;
    endtask

    task automatic check_model();
        n_checks++;
        if (int'(bus.state) != m_state || int'(bus.score_p1) != m_p1 || int'(bus.score_p2) != m_p2 ||
            int'(bus.serve_dir) != m_dir || int'(bus.winner) != m_win ||
            int'(bus.ball_load) != m_load || int'(bus.ball_run) != m_run) begin
            n_fail++;
            $display("FAIL model cyc=%0d got st=%0d p1=%0d p2=%0d dir=%0d win=%0d load=%0d run=%0d want st=%0d p1=%0d p2=%0d dir=%0d win=%0d load=%0d run=%0d",
                     n_cyc, bus.state, bus.score_p1, bus.score_p2, bus.serve_dir, bus.winner, bus.ball_load,
                     bus.ball_run, m_state, m_p1, m_p2, m_dir, m_win, m_load, m_run);
        end
    endtask

    // Called at a falling edge: drive inputs, let one rising edge pass, check at the next falling edge.
    task automatic cyc(input bit ft, input bit st, input bit pa, input bit ml, input bit mr);
        bus.frame_tick = ft; bus.start = st; bus.pause = pa;
        bus.miss_left = ml; bus.miss_right = mr;
        m_step(ft, st, pa, ml, mr);
        @(negedge clk);
        n_cyc++;
        check_model();
        if (bus.ball_load) load_seen++;
    endtask

    task automatic rep(input bit ft, input bit st, input bit pa, input bit ml, input bit mr, input int n);
        for (int i = 0; i < n; i++) begin
            cyc(ft, st, pa, ml, mr);
            cyc(1'b0, st, pa, 1'b0, 1'b0);
        end
    endtask

    initial begin
        bit st_lvl, pa_lvl;
        bus.frame_tick = 0; bus.start = 0; bus.pause = 0; bus.miss_left = 0; bus.miss_right = 0;
        m_reset();

        // ft st pa ml mr  n   state p1 p2 dir win run loads
        tbl.push_back('{0, 1, 0, 0, 0,   1,  1, 0, 0, 0, 0, 0, 1});
        tbl.push_back('{1, 0, 0, 0, 0,  59,  1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0,   1,  2, 0, 0, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 0, 1,   1,  3, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0,  30,  1, 1, 0, 0, 0, 0, 1});
        tbl.push_back('{1, 0, 0, 0, 0,  60,  2, 1, 0, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 1, 0,   1,  3, 1, 1, 1, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0,  30,  1, 1, 1, 1, 0, 0, 1});
        tbl.push_back('{1, 0, 1, 0, 0, 100,  1, 1, 1, 1, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0,  60,  2, 1, 1, 1, 0, 1, 0});
        tbl.push_back('{0, 0, 1, 1, 0,   1,  2, 1, 1, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 1,   1,  3, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0,  30,  1, 1, 1, 0, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 1,   1,  1, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 0,   1,  1, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0,   1,  1, 1, 1, 0, 0, 0, 0});

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk("rst_state", int'(bus.state), 0);
        chk("rst_p1", int'(bus.score_p1), 0);
        chk("rst_p2", int'(bus.score_p2), 0);
        chk("rst_run", int'(bus.ball_run), 0);
        chk("rst_dir", int'(bus.serve_dir), 0);
        chk("rst_winner", int'(bus.winner), 0);

        load_seen = 0;
        for (int i = 0; i < 1000; i++) cyc(0, 0, 0, 0, 0);
        chk("idle_loads", load_seen, 0);
        chk("idle_state", int'(bus.state), 0);

        foreach (tbl[i]) begin
            load_seen = 0;
            rep(tbl[i].ft, tbl[i].st, tbl[i].pa, tbl[i].ml, tbl[i].mr, tbl[i].n);
            chk($sformatf("vec%0d_state", i), int'(bus.state), tbl[i].e_state);
            chk($sformatf("vec%0d_p1", i), int'(bus.score_p1), tbl[i].e_p1);
            chk($sformatf("vec%0d_p2", i), int'(bus.score_p2), tbl[i].e_p2);
            chk($sformatf("vec%0d_dir", i), int'(bus.serve_dir), tbl[i].e_dir);
            chk($sformatf("vec%0d_win", i), int'(bus.winner), tbl[i].e_win);
            chk($sformatf("vec%0d_run", i), int'(bus.ball_run), tbl[i].e_run);
            chk($sformatf("vec%0d_loads", i), load_seen, tbl[i].e_loads);
        end

        // P2 wins the game from 1/1 with ten more left misses.
        for (int k = 2; k <= WIN; k++) begin
            rep(1, 0, 0, 0, 0, SF);
            rep(0, 0, 0, 1, 0, 1);
            chk($sformatf("game_p2_%0d", k), int'(bus.score_p2), k);
            rep(1, 0, 0, 0, 0, PF);
            chk($sformatf("game_state_%0d", k), int'(bus.state), (k < WIN) ? 1 : 4);
        end
        chk("go_winner", int'(bus.winner), 2);
        chk("go_p1", int'(bus.score_p1), 1);
        rep(0, 0, 0, 1, 0, 1);
        rep(1, 0, 0, 0, 0, 40);
        chk("go_p2_hold", int'(bus.score_p2), WIN);
        chk("go_state_hold", int'(bus.state), 4);
        load_seen = 0;
        rep(0, 1, 0, 0, 0, 1);
        chk("restart_state", int'(bus.state), 1);
        chk("restart_p2", int'(bus.score_p2), 0);
        chk("restart_winner", int'(bus.winner), 0);
        chk("restart_loads", load_seen, 1);
        rep(0, 0, 0, 0, 0, 1);

        // Async reset in the middle of a POINT freeze.
        rep(1, 0, 0, 0, 0, SF);
        rep(0, 0, 0, 0, 1, 1);
        rep(1, 0, 0, 0, 0, PF);
        rep(1, 0, 0, 0, 0, SF);
        rep(0, 0, 0, 1, 1, 1);
        chk("both_state", int'(bus.state), 3);
        chk("both_dir", int'(bus.serve_dir), 1);
        chk("both_p1", int'(bus.score_p1), 1);
        rep(1, 0, 0, 0, 0, 10);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_state", int'(bus.state), 0);
        chk("arst_p1", int'(bus.score_p1), 0);
        chk("arst_dir", int'(bus.serve_dir), 0);
        m_reset();
        bus.frame_tick = 0; bus.start = 0; bus.pause = 0; bus.miss_left = 0; bus.miss_right = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Random play against the model.
        st_lvl = 0;
        pa_lvl = 0;
        for (int i = 0; i < 30000; i++) begin
            if ($urandom_range(0, 199) == 0) st_lvl = ~st_lvl;
            if (pa_lvl) begin
                if ($urandom_range(0, 29) == 0) pa_lvl = 0;
            end else if ($urandom_range(0, 299) == 0) begin
                pa_lvl = 1;
            end
            cyc(($urandom_range(0, 2) == 0), st_lvl, pa_lvl,
                ($urandom_range(0, 39) == 0), ($urandom_range(0, 39) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
